sdram_ctrl_if_v2: RTL and testbench
===================================

Name: sdram_ctrl_if_v2

Overview:
- Parametrised second-generation SDRAM control interface.
- Sits between the host command port and the SDRAM command FSM. It decodes host commands into registered one-hot strobes, runs the power-up init sequence (wait, precharge, N auto-refresh, load-mode), and schedules periodic refresh.
- New over gen 1: refresh backlog counting with urgency/overflow flags, optional per-step init ACK handshake, command gating until init completes, and edge-detected CMD_ACK.

Parameters:
- ASIZE, 23, address width.
- INIT_PER, 24000, power-up wait cycles (INIT_REQ high).
- INIT_STEP, 20, cycles between init command issues; min 2.
- INIT_REF_CNT, 8, auto-refresh count during init; min 1.
- INIT_HS, 0: 0 = init strobes are 1-cycle pulses; 1 = each strobe holds until INIT_ACK.
- REF_PER, 1560, cycles between refresh requests.
- REF_MAX_PEND, 8, max queued refreshes; min 1.
- TW, 16, timer width; must hold INIT_PER+(INIT_REF_CNT+3)*INIT_STEP and REF_PER.

Ports:
- CLK in 1: clock.
- RESET_N in 1: asynchronous, active-low reset.
- CMD in 3: host command. 000 NOP, 001 READA, 010 WRITEA, 011 PRECHARGE, 100 LOAD_MODE, 101-111 illegal.
- ADDR in ASIZE: host address.
- REF_ACK in 1: command FSM issued one refresh.
- INIT_ACK in 1: command FSM accepted current init strobe (used only when INIT_HS=1).
- CM_ACK in 1: command FSM accepted host command.
- NOP, READA, WRITEA, PRECHARGE, LOAD_MODE out 1 each: decoded host strobes.
- SADDR out ASIZE: ADDR registered, aligned with strobes.
- CMD_ERR out 1: illegal or pre-init command pulse.
- CMD_ACK out 1: one-cycle pulse per CM_ACK rising edge.
- INIT_REQ out 1: power-up wait in progress.
- INIT_PRECHARGE, INIT_REFRESH, INIT_LOAD_MODE out 1 each: init command strobes.
- INIT_DONE out 1: init complete (level).
- REF_REQ out 1: refresh backlog non-zero.
- REF_URGENT out 1: backlog equals REF_MAX_PEND.
- REF_OVF out 1: sticky, a refresh was lost.
- REF_PEND out clog2(REF_MAX_PEND+1): backlog count.

Behaviour:
- Reset values: INIT_REQ=1; every other output 0, SADDR=0. Reset may assert at any time and restarts the whole init sequence.
- Decode, 1-cycle latency:
  - SADDR<=ADDR every cycle.
  - The single strobe matching CMD is set for one cycle; all other strobes 0.
  - While INIT_DONE=0, any non-NOP CMD gives no strobe and CMD_ERR=1; NOP still decodes.
  - Illegal codes give all strobes 0 and CMD_ERR=1.
- CMD_ACK: registered CM_ACK & ~CM_ACK_d. CM_ACK held high yields exactly one pulse.
- Init FSM states: WAIT -> PRE -> REF -> LMR -> FIN -> DONE.
  - Edge n = nth rising edge after reset release.
  - WAIT: INIT_REQ=1 through edge INIT_PER-1; deasserts at edge INIT_PER.
  - Timed mode (INIT_HS=0), with P=INIT_PER, S=INIT_STEP, N=INIT_REF_CNT:
    - INIT_PRECHARGE high for the cycle following edge P+S.
    - INIT_REFRESH pulse k (k=1..N) at edge P+(k+1)*S.
    - INIT_LOAD_MODE at edge P+(N+2)*S.
    - INIT_DONE at edge P+(N+3)*S, then stays high until reset.
  - INIT_HS=1: each strobe holds until the cycle after INIT_ACK is sampled high. The next S-cycle gap starts from that edge. INIT_ACK outside a strobe is ignored.
  - INIT_DONE=0 throughout the sequence.
- Refresh scheduler, idle until INIT_DONE:
  - On the INIT_DONE edge: timer<=REF_PER-1, pend<=0.
  - Then timer decrements each cycle. At timer==0 a tick occurs: timer reloads REF_PER-1.
  - Backlog rules:
    - Tick without REF_ACK: pend+1, saturating at REF_MAX_PEND. A tick while saturated sets REF_OVF.
    - REF_ACK without tick: pend-1, floored at 0. REF_ACK at 0 is ignored.
    - Tick and REF_ACK together: pend unchanged.
  - REF_ACK before INIT_DONE is ignored.
  - REF_REQ = pend!=0; REF_URGENT = pend==REF_MAX_PEND. Both are registered with pend.

Test Plan:
Overrides for all scenarios: INIT_PER=50, INIT_STEP=4, INIT_REF_CNT=2, REF_PER=20, REF_MAX_PEND=3, INIT_HS=0 unless stated.
1. Release reset, CMD=NOP -> INIT_REQ=1 until edge 50; INIT_PRECHARGE at 54; INIT_REFRESH at 58, 62; INIT_LOAD_MODE at 66; INIT_DONE rises at 70.
2. CMD=001 at cycle 30 -> CMD_ERR pulse, READA=0. After INIT_DONE: CMD=010, ADDR=0x12345 -> next cycle WRITEA=1, SADDR=0x12345. CMD=110 -> CMD_ERR=1, no strobe.
3. No REF_ACK after init -> REF_PEND=1 at edge 90, 2 at 110, 3 with REF_URGENT=1 at 130, REF_OVF=1 at 150. Then REF_ACK for 3 cycles -> REF_PEND=0, REF_REQ=0, REF_OVF stays 1.
4. Pend=1 and REF_ACK coincides with the tick -> REF_PEND stays 1.
5. INIT_HS=1, INIT_ACK delayed 3 cycles per strobe -> each strobe held 3 cycles. Sequence order unchanged; INIT_DONE delayed by 4*3 cycles relative to scenario 1.
6. CM_ACK held high 5 cycles -> single CMD_ACK pulse. RESET_N pulsed low at edge 60 -> all outputs reset, INIT_REQ=1, sequence restarts.

Source files
------------

// File: rtl/sdram_ctrl_if_v2.sv
// rtl/sdram_ctrl_if_v2.sv - SDRAM host command decode, power-up init sequencer and refresh scheduler
module sdram_ctrl_if_v2 #(
    parameter int ASIZE        = 23,
    parameter int INIT_PER     = 24000,
    parameter int INIT_STEP    = 20,
    parameter int INIT_REF_CNT = 8,
    parameter int INIT_HS      = 0,
    parameter int REF_PER      = 1560,
    parameter int REF_MAX_PEND = 8,
    parameter int TW           = 16
) (
    input  logic                              CLK,
    input  logic                              RESET_N,
    input  logic [2:0]                        CMD,
    input  logic [ASIZE-1:0]                  ADDR,
    input  logic                              REF_ACK,
    input  logic                              INIT_ACK,
    input  logic                              CM_ACK,
    output logic                              NOP,
    output logic                              READA,
    output logic                              WRITEA,
    output logic                              PRECHARGE,
    output logic                              LOAD_MODE,
    output logic [ASIZE-1:0]                  SADDR,
    output logic                              CMD_ERR,
    output logic                              CMD_ACK,
    output logic                              INIT_REQ,
    output logic                              INIT_PRECHARGE,
    output logic                              INIT_REFRESH,
    output logic                              INIT_LOAD_MODE,
    output logic                              INIT_DONE,
    output logic                              REF_REQ,
    output logic                              REF_URGENT,
    output logic                              REF_OVF,
    output logic [$clog2(REF_MAX_PEND+1)-1:0] REF_PEND
);
    localparam int PW  = $clog2(REF_MAX_PEND + 1);
    localparam int RCW = $clog2(INIT_REF_CNT + 1);
    localparam logic [TW-1:0]  WAIT_LAST = TW'(INIT_PER - 1);
    localparam logic [TW-1:0]  STEP_LOAD = TW'(INIT_STEP - 1);
    localparam logic [TW-1:0]  REF_LOAD  = TW'(REF_PER - 1);
    localparam logic [RCW-1:0] REF_LAST  = RCW'(INIT_REF_CNT - 1);
    localparam logic [PW-1:0]  PEND_MAX  = PW'(REF_MAX_PEND);
    localparam logic           HS        = (INIT_HS != 0);

    typedef enum logic [2:0] {ST_WAIT, ST_PRE, ST_REF, ST_LMR, ST_FIN, ST_DONE} state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             hold_q, hold_d;
    logic [RCW-1:0]   rcnt_q, rcnt_d;
    logic             init_req_q, init_req_d;
    logic             init_precharge_q, init_precharge_d;
    logic             init_refresh_q, init_refresh_d;
    logic             init_load_mode_q, init_load_mode_d;
    logic             init_done_q, init_done_d;
    logic [PW-1:0]    pend_q, pend_d;
    logic             ref_req_q, ref_req_d;
    logic             ref_urgent_q, ref_urgent_d;
    logic             ref_ovf_q, ref_ovf_d;
    logic             nop_q, nop_d, reada_q, reada_d, writea_q, writea_d;
    logic             precharge_q, precharge_d, load_mode_q, load_mode_d;
    logic             cmd_err_q, cmd_err_d, cmd_ack_q, cmd_ack_d;
    logic             cm_ack_prev_q, cm_ack_prev_d;
    logic [ASIZE-1:0] saddr_q, saddr_d;
    logic             fire, advance, tick;

    always_comb begin
        nop_d         = 1'b0;
        reada_d       = 1'b0;
        writea_d      = 1'b0;
        precharge_d   = 1'b0;
        load_mode_d   = 1'b0;
        cmd_err_d     = 1'b0;
        saddr_d       = ADDR;
        cm_ack_prev_d = CM_ACK;
        cmd_ack_d     = CM_ACK & ~cm_ack_prev_q;
        // Host commands other than NOP are rejected until the SDRAM is initialised
        case (CMD)
            3'b000:  nop_d = 1'b1;
            3'b001:  if (init_done_q) reada_d     = 1'b1; else cmd_err_d = 1'b1;
            3'b010:  if (init_done_q) writea_d    = 1'b1; else cmd_err_d = 1'b1;
            3'b011:  if (init_done_q) precharge_d = 1'b1; else cmd_err_d = 1'b1;
            3'b100:  if (init_done_q) load_mode_d = 1'b1; else cmd_err_d = 1'b1;
            default: cmd_err_d = 1'b1;
        endcase
    end

    always_comb begin
        state_d          = state_q;
        timer_d          = timer_q;
        hold_d           = hold_q;
        rcnt_d           = rcnt_q;
        init_req_d       = init_req_q;
        init_done_d      = init_done_q;
        init_precharge_d = hold_q & init_precharge_q & ~INIT_ACK;
        init_refresh_d   = hold_q & init_refresh_q & ~INIT_ACK;
        init_load_mode_d = hold_q & init_load_mode_q & ~INIT_ACK;
        pend_d           = pend_q;
        ref_ovf_d        = ref_ovf_q;
        fire             = 1'b0;
        advance          = 1'b0;
        tick             = 1'b0;

        // The init timer is reused as the refresh interval timer once init is done
        case (state_q)
            ST_WAIT: begin
                if (timer_q == WAIT_LAST) begin
                    state_d    = ST_PRE;
                    timer_d    = STEP_LOAD;
                    init_req_d = 1'b0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_PRE, ST_REF, ST_LMR: begin
                if (hold_q) begin
                    advance = INIT_ACK;
                end else if (timer_q == '0) begin
                    fire    = 1'b1;
                    advance = !HS;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_FIN: begin
                if (timer_q == '0) begin
                    state_d     = ST_DONE;
                    init_done_d = 1'b1;
                    timer_d     = REF_LOAD;
                    pend_d      = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_DONE: begin
                if (timer_q == '0) begin
                    tick    = 1'b1;
                    timer_d = REF_LOAD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = ST_WAIT;
        endcase

        if (fire) begin
            hold_d = HS;
            case (state_q)
                ST_PRE:  init_precharge_d = 1'b1;
                ST_REF:  init_refresh_d   = 1'b1;
                ST_LMR:  init_load_mode_d = 1'b1;
                default: ;
            endcase
        end

        // Step complete: either the pulse went out (timed) or it was acknowledged
        if (advance) begin
            hold_d  = 1'b0;
            timer_d = STEP_LOAD;
            case (state_q)
                ST_PRE: begin
                    state_d = ST_REF;
                    rcnt_d  = '0;
                end
                ST_REF: begin
                    if (rcnt_q == REF_LAST) state_d = ST_LMR;
                    else                    rcnt_d  = rcnt_q + 1'b1;
                end
                ST_LMR:  state_d = ST_FIN;
                default: ;
            endcase
        end

        if (state_q == ST_DONE) begin
            if (tick && !REF_ACK) begin
                if (pend_q == PEND_MAX) ref_ovf_d = 1'b1;
                else                    pend_d    = pend_q + 1'b1;
            end else if (!tick && REF_ACK && pend_q != '0) begin
                pend_d = pend_q - 1'b1;
            end
        end

        ref_req_d    = (pend_d != '0);
        ref_urgent_d = (pend_d == PEND_MAX);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q          <= ST_WAIT;
            timer_q          <= '0;
            hold_q           <= 1'b0;
            rcnt_q           <= '0;
            init_req_q       <= 1'b1;
            init_precharge_q <= 1'b0;
            init_refresh_q   <= 1'b0;
            init_load_mode_q <= 1'b0;
            init_done_q      <= 1'b0;
            pend_q           <= '0;
            ref_req_q        <= 1'b0;
            ref_urgent_q     <= 1'b0;
            ref_ovf_q        <= 1'b0;
            nop_q            <= 1'b0;
            reada_q          <= 1'b0;
            writea_q         <= 1'b0;
            precharge_q      <= 1'b0;
            load_mode_q      <= 1'b0;
            cmd_err_q        <= 1'b0;
            cmd_ack_q        <= 1'b0;
            cm_ack_prev_q    <= 1'b0;
            saddr_q          <= '0;
        end else begin
            state_q          <= state_d;
            timer_q          <= timer_d;
            hold_q           <= hold_d;
            rcnt_q           <= rcnt_d;
            init_req_q       <= init_req_d;
            init_precharge_q <= init_precharge_d;
            init_refresh_q   <= init_refresh_d;
            init_load_mode_q <= init_load_mode_d;
            init_done_q      <= init_done_d;
            pend_q           <= pend_d;
            ref_req_q        <= ref_req_d;
            ref_urgent_q     <= ref_urgent_d;
            ref_ovf_q        <= ref_ovf_d;
            nop_q            <= nop_d;
            reada_q          <= reada_d;
            writea_q         <= writea_d;
            precharge_q      <= precharge_d;
            load_mode_q      <= load_mode_d;
            cmd_err_q        <= cmd_err_d;
            cmd_ack_q        <= cmd_ack_d;
            cm_ack_prev_q    <= cm_ack_prev_d;
            saddr_q          <= saddr_d;
        end
    end

    assign NOP            = nop_q;
    assign READA          = reada_q;
    assign WRITEA         = writea_q;
    assign PRECHARGE      = precharge_q;
    assign LOAD_MODE      = load_mode_q;
    assign SADDR          = saddr_q;
    assign CMD_ERR        = cmd_err_q;
    assign CMD_ACK        = cmd_ack_q;
    assign INIT_REQ       = init_req_q;
    assign INIT_PRECHARGE = init_precharge_q;
    assign INIT_REFRESH   = init_refresh_q;
    assign INIT_LOAD_MODE = init_load_mode_q;
    assign INIT_DONE      = init_done_q;
    assign REF_REQ        = ref_req_q;
    assign REF_URGENT     = ref_urgent_q;
    assign REF_OVF        = ref_ovf_q;
    assign REF_PEND       = pend_q;

endmodule

// File: tb/tb_sdram_ctrl_if_v2.sv
// tb/tb_sdram_ctrl_if_v2.sv - bench for sdram_ctrl_if_v2, timed and handshake init variants side by side
module tb_sdram_ctrl_if_v2;
    localparam int ASZ = 23, P = 50, S = 4, N = 2, RP = 20, MP = 3, H = 3;
    localparam logic [39:0] RST_VEC = 40'h01_0000_0000;

    logic           CLK, RESET_N;
    logic [2:0]     CMD;
    logic [ASZ-1:0] ADDR;
    logic           REF_ACK, INIT_ACK, CM_ACK;
    logic [1:0]     nop, reada, writea, prech, lmode, cmd_err, cmd_ack, init_req;
    logic [1:0]     i_pre, i_ref, i_lmr, i_done, ref_req, ref_urg, ref_ovf;
    logic [ASZ-1:0] saddr [2];
    logic [1:0]     pend  [2];

    int             checks = 0, errors = 0, n = 0;
    int             m_pend [2];
    logic           m_ovf  [2];
    logic           m_prev_ack;
    logic [39:0]    exp_vec [2];

    sdram_ctrl_if_v2 #(.ASIZE(ASZ), .INIT_PER(P), .INIT_STEP(S), .INIT_REF_CNT(N), .INIT_HS(0),
                       .REF_PER(RP), .REF_MAX_PEND(MP), .TW(16)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .CMD(CMD), .ADDR(ADDR), .REF_ACK(REF_ACK), .INIT_ACK(INIT_ACK),
        .CM_ACK(CM_ACK), .NOP(nop[0]), .READA(reada[0]), .WRITEA(writea[0]), .PRECHARGE(prech[0]),
        .LOAD_MODE(lmode[0]), .SADDR(saddr[0]), .CMD_ERR(cmd_err[0]), .CMD_ACK(cmd_ack[0]),
        .INIT_REQ(init_req[0]), .INIT_PRECHARGE(i_pre[0]), .INIT_REFRESH(i_ref[0]),
        .INIT_LOAD_MODE(i_lmr[0]), .INIT_DONE(i_done[0]), .REF_REQ(ref_req[0]),
        .REF_URGENT(ref_urg[0]), .REF_OVF(ref_ovf[0]), .REF_PEND(pend[0]));

    sdram_ctrl_if_v2 #(.ASIZE(ASZ), .INIT_PER(P), .INIT_STEP(S), .INIT_REF_CNT(N), .INIT_HS(1),
                       .REF_PER(RP), .REF_MAX_PEND(MP), .TW(16)) dut_hs (
        .CLK(CLK), .RESET_N(RESET_N), .CMD(CMD), .ADDR(ADDR), .REF_ACK(REF_ACK), .INIT_ACK(INIT_ACK),
        .CM_ACK(CM_ACK), .NOP(nop[1]), .READA(reada[1]), .WRITEA(writea[1]), .PRECHARGE(prech[1]),
        .LOAD_MODE(lmode[1]), .SADDR(saddr[1]), .CMD_ERR(cmd_err[1]), .CMD_ACK(cmd_ack[1]),
        .INIT_REQ(init_req[1]), .INIT_PRECHARGE(i_pre[1]), .INIT_REFRESH(i_ref[1]),
        .INIT_LOAD_MODE(i_lmr[1]), .INIT_DONE(i_done[1]), .REF_REQ(ref_req[1]),
        .REF_URGENT(ref_urg[1]), .REF_OVF(ref_ovf[1]), .REF_PEND(pend[1]));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Handshake responder: acknowledges a held init strobe in its third cycle, random noise otherwise
    initial begin
        int hc;
        hc = 0;
        INIT_ACK = 1'b0;
        forever begin
            @(negedge CLK);
            if (i_pre[1] || i_ref[1] || i_lmr[1]) begin
                hc++;
                INIT_ACK = (hc >= H);
            end else begin
                hc = 0;
                INIT_ACK = 1'($urandom_range(0, 1));
            end
        end
    end

    function automatic logic [39:0] act(input int d);
        return {nop[d], reada[d], writea[d], prech[d], lmode[d], cmd_err[d], cmd_ack[d], init_req[d],
                i_pre[d], i_ref[d], i_lmr[d], i_done[d], ref_req[d], ref_urg[d], ref_ovf[d], pend[d], saddr[d]};
    endfunction

    function automatic int done_edge(input int d);
        return P + S * (N + 3) + ((d == 1) ? H * (N + 2) : 0);
    endfunction

    function automatic logic strobe_on(input int d, input int i, input int e);
        int st, len;
        st  = P + S * (i + 1) + ((d == 1) ? H * i : 0);
        len = (d == 1) ? H : 1;
        return (e >= st) && (e < st + len);
    endfunction

    task automatic chk(input string name, input logic [39:0] actual, input logic [39:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s edge=%0d actual=%h expected=%h", name, n, actual, expected);
        end
    endtask

    task automatic model(input logic [2:0] cmd, input logic [ASZ-1:0] addr, input logic cmack, input logic refack);
        for (int d = 0; d < 2; d++) begin
            int dn;
            logic [5:0] dec;
            logic tick, ipre, iref, ilm;
            dn  = done_edge(d);
            dec = '0;
            if (cmd == 3'd0)                         dec[5] = 1'b1;
            else if (cmd > 3'd4 || (n - 1) < dn)     dec[0] = 1'b1;
            else                                     dec[5 - int'(cmd)] = 1'b1;
            if (n == dn) begin
                m_pend[d] = 0;
            end else if (n > dn) begin
                tick = ((n - dn) % RP) == 0;
                if (tick && !refack) begin
                    if (m_pend[d] == MP) m_ovf[d] = 1'b1;
                    else                 m_pend[d]++;
                end else if (!tick && refack && m_pend[d] > 0) begin
                    m_pend[d]--;
                end
            end
            ipre = strobe_on(d, 0, n);
            iref = 1'b0;
            for (int k = 1; k <= N; k++) iref |= strobe_on(d, k, n);
            ilm  = strobe_on(d, N + 1, n);
            exp_vec[d] = {dec, cmack & ~m_prev_ack, logic'(n < P), ipre, iref, ilm, logic'(n >= dn),
                          logic'(m_pend[d] != 0), logic'(m_pend[d] == MP), m_ovf[d], 2'(m_pend[d]), addr};
        end
        m_prev_ack = cmack;
    endtask

    task automatic step(input logic [2:0] cmd, input logic [ASZ-1:0] addr, input logic cmack, input logic refack);
        CMD = cmd; ADDR = addr; CM_ACK = cmack; REF_ACK = refack;
        @(posedge CLK);
        n++;
        model(cmd, addr, cmack, refack);
        #1;
        chk("dut_timed", act(0), exp_vec[0]);
        chk("dut_hs", act(1), exp_vec[1]);
    endtask

    task automatic rstep(input int ack_one_in);
        step(3'($urandom_range(0, 7)), ASZ'($urandom), 1'($urandom_range(0, 1)),
             (ack_one_in > 0) ? logic'($urandom_range(1, ack_one_in) == 1) : 1'b0);
    endtask

    task automatic reset_pulse(input string tag);
        RESET_N = 1'b0;
        #2;
        chk({tag, "_async_timed"}, act(0), RST_VEC);
        chk({tag, "_async_hs"}, act(1), RST_VEC);
        repeat (2) @(posedge CLK);
        #1;
        chk({tag, "_held_timed"}, act(0), RST_VEC);
        @(negedge CLK);
        RESET_N = 1'b1;
        n = 0;
        m_pend[0] = 0; m_pend[1] = 0;
        m_ovf[0] = 1'b0; m_ovf[1] = 1'b0;
        m_prev_ack = 1'b0;
    endtask

    typedef struct {
        logic [2:0]     cmd;
        logic [ASZ-1:0] addr;
        logic [5:0]     dec;
    } vec_t;
    vec_t tbl [10];

    initial begin
        int pulses;
        tbl[0] = '{3'b010, 23'h012345, 6'b001000};
        tbl[1] = '{3'b110, 23'h000abc, 6'b000001};
        tbl[2] = '{3'b000, 23'h7fffff, 6'b100000};
        tbl[3] = '{3'b001, 23'h400000, 6'b010000};
        tbl[4] = '{3'b011, 23'h000001, 6'b000100};
        tbl[5] = '{3'b100, 23'h2aaaaa, 6'b000010};
        tbl[6] = '{3'b101, 23'h555555, 6'b000001};
        tbl[7] = '{3'b111, 23'h000000, 6'b000001};
        tbl[8] = '{3'b010, 23'h7fffff, 6'b001000};
        tbl[9] = '{3'b000, 23'h000000, 6'b100000};

        RESET_N = 1'b1; CMD = '0; ADDR = '0; REF_ACK = 1'b0; CM_ACK = 1'b0;
        #1;
        reset_pulse("rst_initial");

        // Init sequence, pre-init rejection, backlog saturation/overflow, tick+ack coincidence
        for (int e = 1; e <= 200; e++) begin
            logic [2:0] c;
            logic       ra;
            c  = (e == 30) ? 3'b001 : 3'($urandom_range(0, 7));
            ra = (e >= 151 && e <= 153) || (e == 190);
            step(c, ASZ'($urandom), 1'($urandom_range(0, 1)), ra);
            if (n == 30)  chk("pre_init_reada", {38'd0, reada[0], cmd_err[0]}, 40'b01);
            if (n == 69)  chk("done_not_yet", {39'd0, i_done[0]}, 40'd0);
            if (n == 70)  chk("done_at_70", {39'd0, i_done[0]}, 40'd1);
            if (n == 82)  chk("hs_done_at_82", {38'd0, i_done}, 40'b11);
            if (n == 130) chk("urgent_at_130", {37'd0, ref_urg[0], pend[0]}, 40'b111);
            if (n == 150) chk("ovf_at_150", {37'd0, ref_ovf[0], pend[0]}, 40'b111);
            if (n == 153) chk("drained_at_153", {37'd0, ref_ovf[0], ref_req[0], pend[0]}, 40'b1000);
            if (n == 190) chk("tick_ack_at_190", {38'd0, pend[0]}, 40'd1);
        end

        foreach (tbl[i]) begin
            step(tbl[i].cmd, tbl[i].addr, 1'b0, 1'b0);
            chk("tbl_decode", {34'd0, nop[0], reada[0], writea[0], prech[0], lmode[0], cmd_err[0]}, {34'd0, tbl[i].dec});
            chk("tbl_saddr", {17'd0, saddr[0]}, {17'd0, tbl[i].addr});
        end

        for (int e = 0; e < 250; e++) rstep(4);

        step(3'b000, '0, 1'b0, 1'b0);
        pulses = 0;
        for (int e = 0; e < 5; e++) begin
            step(3'b000, '0, 1'b1, 1'b0);
            pulses += int'(cmd_ack[0]);
        end
        step(3'b000, '0, 1'b0, 1'b0);
        pulses += int'(cmd_ack[0]);
        chk("cm_ack_single_pulse", 40'(pulses), 40'd1);

        reset_pulse("rst_after_done");
        for (int e = 0; e < 60; e++) rstep(0);
        reset_pulse("rst_at_60");
        for (int e = 0; e < 100; e++) rstep(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
